// File: rtl/sel_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sel_burst_decoder
// Brief    : Accepts {index, count} burst commands and emits one-hot register
//            strobes, one per handshake beat. Optional macro SEL_DEC_ERR_CHK_EN
//            drops zero-count commands and pulses err.
// Revision : 1.0 - initial release
// ============================================================================
module sel_burst_decoder (
    input  logic        clock,
    input  logic        clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_index,
    input  logic [4:0]  cmd_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_onehot,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [4:0] r_index;
    logic [5:0] r_remaining;

    logic       w_accept;
    logic       w_start;
    logic       w_xfer;
    logic [5:0] w_count_ext;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_xfer      = (r_state == S_RUN) && out_ready;
    // A zero count field encodes a full 32-beat sweep.
    assign w_count_ext = (cmd_count == 5'd0) ? 6'd32 : {1'b0, cmd_count};

`ifdef SEL_DEC_ERR_CHK_EN
    logic r_err;

    assign w_start = w_accept && (cmd_count != 5'd0);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (cmd_count == 5'd0);
        end
    end

    assign err = r_err;
`else
    assign w_start = w_accept;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_index     <= 5'd0;
            r_remaining <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_index     <= cmd_index;
                r_remaining <= w_count_ext;
            end else if (w_xfer) begin
                r_index     <= r_index + 5'd1;
                r_remaining <= r_remaining - 6'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_RUN;
            S_RUN:  if (w_xfer && (r_remaining == 6'd1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        out_valid  = 1'b0;
        out_onehot = 32'h0;
        out_index  = 5'd0;
        out_last   = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready = 1'b1;
            S_RUN: begin
                out_valid  = 1'b1;
                out_onehot = 32'h1 << r_index;
                out_index  = r_index;
                out_last   = (r_remaining == 6'd1);
                busy       = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire
